// File: rtl/axis_read_pkg.sv
// Shared definitions for the stream read/write engines: one-hot FSM encoding,
// configuration word count and the AXI-to-stream width ratio helper.
package axis_read_pkg;

  localparam int unsigned C_IDLE   = 0;
  localparam int unsigned C_CONFIG = 1;
  localparam int unsigned C_START  = 2;
  localparam int unsigned C_RUN    = 3;

  localparam int unsigned CFG_NB = 2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'(1 << C_IDLE),
    S_CONFIG = 4'(1 << C_CONFIG),
    S_START  = 4'(1 << C_START),
    S_RUN    = 4'(1 << C_RUN)
  } state_t;

  function automatic int unsigned ratio_shift(input int unsigned axi_w, input int unsigned w);
    return $clog2(axi_w / w);
  endfunction

endpackage

// File: rtl/axis_read_data.sv
// Read-data path: beat FIFO, LSB-first unpack shift register, remaining word
// counter and the registered valid/ready stream output.
module axis_read_data
  import axis_read_pkg::*;
#(
  parameter int unsigned BUF_AWIDTH     = 9,
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [CFG_DWIDTH-1:0]     length,
  input  logic                      run,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  input  logic                      ready,
  output logic [BUF_AWIDTH:0]       fifo_count,
  output logic                      fifo_empty,
  output logic                      words_done
);

  localparam int unsigned DEPTH = 1 << BUF_AWIDTH;
  localparam int unsigned RATIO = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned SW    = ratio_shift(AXI_DATA_WIDTH, DATA_WIDTH) + 1;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_AWIDTH-1:0]     wr_ptr, rd_ptr;
  logic [BUF_AWIDTH:0]       count;
  logic [AXI_DATA_WIDTH-1:0] sh, sh_next;
  logic [SW-1:0]             slots;
  logic [CFG_DWIDTH-1:0]     words_rem;
  logic                      full, push, pop, adv, last_slot, more;

  assign full       = count[BUF_AWIDTH];
  assign fifo_empty = (count == '0);
  assign fifo_count = count;
  assign words_done = (words_rem == '0);
  assign axi_rready = run & ~full;
  assign push       = axi_rvalid & axi_rready;
  assign data       = sh[DATA_WIDTH-1:0];

  // A slot is the last one either at the end of the beat or at the end of the
  // transfer; the next beat is popped in that same cycle to keep throughput.
  assign adv       = valid & ready;
  assign last_slot = (slots == SW'(1)) || (words_rem == CFG_DWIDTH'(1));
  assign more      = adv ? (words_rem != CFG_DWIDTH'(1)) : (words_rem != '0);
  assign pop       = (~valid | (adv & last_slot)) & more & ~fifo_empty;

  if (RATIO > 1) begin : g_shift
    assign sh_next = {{DATA_WIDTH{1'b0}}, sh[AXI_DATA_WIDTH-1:DATA_WIDTH]};
  end else begin : g_noshift
    assign sh_next = '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axi_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sh        <= '0;
      slots     <= '0;
      words_rem <= '0;
      valid     <= 1'b0;
    end else begin
      assert (!(run && axi_rvalid && full));
      if (push) wr_ptr <= wr_ptr + BUF_AWIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + BUF_AWIDTH'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (BUF_AWIDTH+1)'(1);
        2'b01:   count <= count - (BUF_AWIDTH+1)'(1);
        default: count <= count;
      endcase
      if (load)     words_rem <= length;
      else if (adv) words_rem <= words_rem - CFG_DWIDTH'(1);
      if (pop) begin
        sh    <= mem[rd_ptr];
        slots <= SW'(RATIO);
        valid <= 1'b1;
      end else if (adv && last_slot) begin
        slots <= '0;
        valid <= 1'b0;
      end else if (adv) begin
        sh    <= sh_next;
        slots <= slots - SW'(1);
      end
    end
  end

endmodule

// File: rtl/axis_read.sv
// Memory-to-stream engine: cfg-bus setup FSM and AXI AR issue with FIFO credit
// control; data buffering and unpacking live in axis_read_data.
module axis_read
  import axis_read_pkg::*;
#(
  parameter int unsigned BUF_AWIDTH     = 9,
  parameter int unsigned CFG_ID         = 2,
  parameter int unsigned CFG_ADDR       = 23,
  parameter int unsigned CFG_DATA       = 24,
  parameter int unsigned CFG_AWIDTH     = 5,
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned AXI_LEN_WIDTH  = 8,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_AWIDTH-1:0]     cfg_addr,
  input  logic [CFG_DWIDTH-1:0]     cfg_data,
  input  logic                      cfg_valid,
  input  logic                      axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic                      axi_arvalid,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      busy
);

  localparam int unsigned CW         = CFG_DWIDTH;
  localparam int unsigned RATIO      = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned RSHIFT     = ratio_shift(AXI_DATA_WIDTH, DATA_WIDTH);
  localparam int unsigned BEAT_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [CW-1:0] RMASK     = CW'(RATIO - 1);
  localparam logic [CW-1:0] BUF_DEPTH = CW'(1) << BUF_AWIDTH;

  state_t              state;
  logic                cfg_cnt;
  logic [CW-1:0]       start_addr, length, beats_rem, outstanding, ar_burst, burst;
  logic [BUF_AWIDTH:0] fifo_count;
  logic                fifo_empty, words_done, ar_acc, r_beat, credit_ok;
  logic                rlast_unused;

  assign rlast_unused = axi_rlast;
  assign ar_acc    = axi_arvalid & axi_arready;
  assign r_beat    = axi_rvalid & axi_rready;
  assign burst     = (beats_rem > CW'(MAX_BURST)) ? CW'(MAX_BURST) : beats_rem;
  assign credit_ok = (CW'(fifo_count) + outstanding + burst) <= BUF_DEPTH;

  axis_read_data #(
    .BUF_AWIDTH     (BUF_AWIDTH),
    .CFG_DWIDTH     (CFG_DWIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_data (
    .clk        (clk),
    .rst        (rst),
    .load       (state == S_START),
    .length     (length),
    .run        (state == S_RUN),
    .axi_rdata  (axi_rdata),
    .axi_rvalid (axi_rvalid),
    .axi_rready (axi_rready),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .words_done (words_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg_cnt     <= 1'b0;
      start_addr  <= '0;
      length      <= '0;
      beats_rem   <= '0;
      outstanding <= '0;
      ar_burst    <= '0;
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_ADDR) && cfg_data == CW'(CFG_ID)) begin
            state   <= S_CONFIG;
            cfg_cnt <= 1'b0;
          end
        end
        S_CONFIG: begin
          if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_DATA)) begin
            if (!cfg_cnt) begin
              start_addr <= cfg_data;
              cfg_cnt    <= 1'b1;
            end else begin
              length <= cfg_data;
              state  <= S_START;
              busy   <= 1'b1;
            end
          end
        end
        S_START: begin
          beats_rem  <= (length >> RSHIFT) + CW'(|(length & RMASK));
          axi_araddr <= AXI_ADDR_WIDTH'(start_addr);
          if (length == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (beats_rem == '0 && words_done && fifo_empty) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          if (!axi_arvalid && beats_rem != '0 && credit_ok) begin
            axi_arvalid <= 1'b1;
            axi_arlen   <= AXI_LEN_WIDTH'(burst - CW'(1));
            ar_burst    <= burst;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Accept can only occur in RUN, so it safely overrides the case above.
      if (ar_acc) begin
        axi_arvalid <= 1'b0;
        axi_araddr  <= axi_araddr + AXI_ADDR_WIDTH'(ar_burst << BEAT_SHIFT);
        beats_rem   <= beats_rem - ar_burst;
      end
      outstanding <= outstanding + (ar_acc ? ar_burst : '0) - CW'(r_beat);
    end
  end

endmodule

// File: tb/tb_axis_read.sv
// Directed bench for axis_read: two engines on a shared cfg bus (32-bit and
// 64-bit AXI) with behavioural AXI read slaves returning address-tagged data.
module tb_axis_read;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;

  logic        a_arready, a_arvalid, a_rlast, a_rvalid, a_rready, a_valid, a_ready, a_busy;
  logic [31:0] a_araddr, a_rdata, a_data;
  logic [7:0]  a_arlen;
  logic        b_arready, b_arvalid, b_rlast, b_rvalid, b_rready, b_valid, b_ready, b_busy;
  logic [31:0] b_araddr, b_data;
  logic [63:0] b_rdata;
  logic [7:0]  b_arlen;

  axis_read #(.BUF_AWIDTH(5), .CFG_ID(2)) dut_a (
    .clk(clk), .rst(rst), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .axi_arready(a_arready), .axi_araddr(a_araddr), .axi_arlen(a_arlen), .axi_arvalid(a_arvalid),
    .axi_rdata(a_rdata), .axi_rlast(a_rlast), .axi_rvalid(a_rvalid), .axi_rready(a_rready),
    .data(a_data), .valid(a_valid), .ready(a_ready), .busy(a_busy));

  axis_read #(.CFG_ID(3), .AXI_DATA_WIDTH(64), .DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .axi_arready(b_arready), .axi_araddr(b_araddr), .axi_arlen(b_arlen), .axi_arvalid(b_arvalid),
    .axi_rdata(b_rdata), .axi_rlast(b_rlast), .axi_rvalid(b_rvalid), .axi_rready(b_rready),
    .data(b_data), .valid(b_valid), .ready(b_ready), .busy(b_busy));

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'hD000_0000 ^ a;
  endfunction

  typedef struct {logic [31:0] addr; logic last;} beat_t;
  beat_t       qa[$], qb[$];
  logic [31:0] ar_addr_a[$], ar_addr_b[$], out_a[$], out_b[$];
  logic [7:0]  ar_len_a[$], ar_len_b[$];
  int          out_cyc_a[$];
  int          cyc = 0, busy_cyc_a = 0;
  int          tests = 0, fails = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      qa.delete(); qb.delete();
      a_rvalid <= 1'b0; b_rvalid <= 1'b0;
    end else begin
      if (a_rvalid && a_rready) void'(qa.pop_front());
      if (a_arvalid && a_arready) begin
        ar_addr_a.push_back(a_araddr); ar_len_a.push_back(a_arlen);
        for (int i = 0; i <= int'(a_arlen); i++) qa.push_back('{a_araddr + 32'(4*i), i == int'(a_arlen)});
      end
      a_rvalid <= (qa.size() != 0);
      if (qa.size() != 0) begin a_rdata <= f(qa[0].addr); a_rlast <= qa[0].last; end
      if (b_rvalid && b_rready) void'(qb.pop_front());
      if (b_arvalid && b_arready) begin
        ar_addr_b.push_back(b_araddr); ar_len_b.push_back(b_arlen);
        for (int i = 0; i <= int'(b_arlen); i++) qb.push_back('{b_araddr + 32'(8*i), i == int'(b_arlen)});
      end
      b_rvalid <= (qb.size() != 0);
      if (qb.size() != 0) begin b_rdata <= {f(qb[0].addr + 32'd4), f(qb[0].addr)}; b_rlast <= qb[0].last; end
      if (a_valid && a_ready) begin out_a.push_back(a_data); out_cyc_a.push_back(cyc); end
      if (b_valid && b_ready) out_b.push_back(b_data);
      if (a_busy) busy_cyc_a++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [4:0] a, input logic [31:0] d);
    cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic clear_logs();
    ar_addr_a.delete(); ar_len_a.delete(); out_a.delete(); out_cyc_a.delete();
    ar_addr_b.delete(); ar_len_b.delete(); out_b.delete();
  endtask

  task automatic wait_a(input int n);
    for (int i = 0; i < 2000 && out_a.size() < n; i++) @(negedge clk);
    for (int i = 0; i < 50 && a_busy; i++) @(negedge clk);
  endtask

  function automatic int errs_a(input logic [31:0] base);
    int e = 0;
    foreach (out_a[i]) if (out_a[i] !== f(base + 32'(4*i))) e++;
    return e;
  endfunction

  initial begin
    logic [31:0] ea2[3];
    logic [7:0]  el2[3];
    int          gap;
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    a_ready = 1'b0; b_ready = 1'b0; a_arready = 1'b1; b_arready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {a_arvalid, a_rready, a_valid, a_busy}, 4'b0);
    chk("rst_araddr", a_araddr, 32'h0);
    chk("rst_arlen", a_arlen, 8'h0);
    chk("rst_data", a_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Length 8, RATIO 1
    clear_logs(); a_ready = 1'b1;
    cfg(5'd23, 32'd2); cfg(5'd24, 32'h1000); cfg(5'd24, 32'd8);
    chk("t1_busy_start", a_busy, 1'b1);
    wait_a(8);
    chk("t1_ar_n", ar_addr_a.size(), 1);
    chk("t1_ar_addr", ar_addr_a.size() > 0 ? ar_addr_a[0] : 'x, 32'h1000);
    chk("t1_ar_len", ar_len_a.size() > 0 ? ar_len_a[0] : 'x, 8'd7);
    chk("t1_words", out_a.size(), 8);
    chk("t1_data_errs", errs_a(32'h1000), 0);
    gap = (out_cyc_a.size() >= 8) ? out_cyc_a[7] - out_cyc_a[0] : -1;
    chk("t1_back2back", gap, 7);
    chk("t1_busy_end", a_busy, 1'b0);

    // Length 40: three bursts; a select write mid-run must be ignored
    clear_logs();
    cfg(5'd23, 32'd2); cfg(5'd24, 32'h1000); cfg(5'd24, 32'd40);
    repeat (5) @(negedge clk);
    cfg(5'd23, 32'd2);
    wait_a(40);
    ea2 = '{32'h1000, 32'h1040, 32'h1080};
    el2 = '{8'd15, 8'd15, 8'd7};
    chk("t2_ar_n", ar_addr_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_ar_addr", i < ar_addr_a.size() ? ar_addr_a[i] : 'x, ea2[i]);
      chk("t2_ar_len", i < ar_len_a.size() ? ar_len_a[i] : 'x, el2[i]);
    end
    chk("t2_words", out_a.size(), 40);
    chk("t2_data_errs", errs_a(32'h1000), 0);
    chk("t2_busy_end", a_busy, 1'b0);

    // 64-bit AXI, length 5: upper half of the third beat is discarded
    clear_logs(); b_ready = 1'b1;
    cfg(5'd23, 32'd3); cfg(5'd24, 32'h1000); cfg(5'd24, 32'd5);
    for (int i = 0; i < 500 && (out_b.size() < 5 || b_busy); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t3_ar_n", ar_addr_b.size(), 1);
    chk("t3_ar_addr", ar_addr_b.size() > 0 ? ar_addr_b[0] : 'x, 32'h1000);
    chk("t3_ar_len", ar_len_b.size() > 0 ? ar_len_b[0] : 'x, 8'd2);
    chk("t3_words", out_b.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t3_word", i < out_b.size() ? out_b[i] : 'x, f(32'h1000 + 32'(4*i)));
    chk("t3_busy_end", b_busy, 1'b0);
    chk("t3_other_idle", a_busy, 1'b0);

    // Length 0: one cycle of busy, no traffic
    clear_logs(); busy_cyc_a = 0;
    cfg(5'd23, 32'd2); cfg(5'd24, 32'h1000); cfg(5'd24, 32'd0);
    repeat (6) @(negedge clk);
    chk("t4_busy_cycles", busy_cyc_a, 1);
    chk("t4_ar_n", ar_addr_a.size(), 0);
    chk("t4_words", out_a.size(), 0);

    // Credit stall with a 32-beat buffer and consumer held off
    clear_logs(); a_ready = 1'b0; a_arready = 1'b0;
    cfg(5'd23, 32'd2); cfg(5'd24, 32'h2000); cfg(5'd24, 32'd100);
    repeat (4) @(negedge clk);
    chk("t5_arvalid", a_arvalid, 1'b1);
    chk("t5_araddr", a_araddr, 32'h2000);
    chk("t5_arlen", a_arlen, 8'd15);
    repeat (6) @(negedge clk);
    chk("t5_hold", {a_arvalid, a_araddr, a_arlen}, {1'b1, 32'h2000, 8'd15});
    a_arready = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_stall_ar_n", ar_addr_a.size(), 2);
    chk("t5_stall_arvalid", a_arvalid, 1'b0);
    chk("t5_held_word", {a_valid, a_data}, {1'b1, f(32'h2000)});
    chk("t5_stall_words", out_a.size(), 0);
    a_ready = 1'b1;
    wait_a(100);
    chk("t5_ar_n", ar_addr_a.size(), 7);
    chk("t5_last_addr", ar_addr_a.size() == 7 ? ar_addr_a[6] : 'x, 32'h2180);
    chk("t5_last_len", ar_len_a.size() == 7 ? ar_len_a[6] : 'x, 8'd3);
    chk("t5_words", out_a.size(), 100);
    chk("t5_data_errs", errs_a(32'h2000), 0);

    // Reset mid-run, then a fresh transfer
    clear_logs();
    cfg(5'd23, 32'd2); cfg(5'd24, 32'h3000); cfg(5'd24, 32'd40);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ctrl", {a_arvalid, a_rready, a_valid, a_busy}, 4'b0);
    chk("t6_rst_ar", {a_araddr, a_arlen}, 40'h0);
    chk("t6_rst_data", a_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    cfg(5'd23, 32'd2); cfg(5'd24, 32'h4000); cfg(5'd24, 32'd8);
    wait_a(8);
    chk("t6_ar", {ar_addr_a.size() > 0 ? ar_addr_a[0] : 32'hx, ar_len_a.size() > 0 ? ar_len_a[0] : 8'hx}, {32'h4000, 8'd7});
    chk("t6_words", out_a.size(), 8);
    chk("t6_data_errs", errs_a(32'h4000), 0);
    chk("t6_busy_end", a_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
